// File: rtl/w0rm_core_branch_ras.sv
`default_nettype none
// ============================================================================
// Module      : w0rm_core_branch_ras
// Description : W0RM branch resolution unit with a return-address stack.
//               Evaluates the condition code against the ALU flags and picks a
//               RAS, relative or absolute target. Calls push and returns pop
//               the stack. The resolved next_pc / flush reach fetch through 1
//               or 2 stallable register stages.
// Ports       : clk, reset_n (async, active low)
//               data_valid / branch_ready          : input handshake
//               is_branch, is_cond_branch, cond_branch_code, is_call,
//               is_return, alu_flag_*              : decode + flags
//               branch_base_addr, branch_rel_abs, rn, lit : target operands
//               user_data_in / user_data_out       : sideband
//               mem_ready / result_valid           : output handshake
//               branch_valid, flush_pipeline, next_pc, next_pc_valid : result
//               ras_overflow                       : sticky overwrite flag
// Revision    : 1.0 - initial release
// ============================================================================
module w0rm_core_branch_ras #(
    parameter int DATA_WIDTH  = 32,
    parameter int USER_WIDTH  = 1,
    parameter int PIPE_STAGES = 1,
    parameter int RAS_DEPTH   = 8,
    parameter int INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_valid,
    output logic                  branch_ready,
    input  logic                  is_branch,
    input  logic                  is_cond_branch,
    input  logic [3:0]            cond_branch_code,
    input  logic                  is_call,
    input  logic                  is_return,
    input  logic                  alu_flag_zero,
    input  logic                  alu_flag_negative,
    input  logic                  alu_flag_carry,
    input  logic                  alu_flag_overflow,
    input  logic [DATA_WIDTH-1:0] branch_base_addr,
    input  logic                  branch_rel_abs,
    input  logic [DATA_WIDTH-1:0] rn,
    input  logic [DATA_WIDTH-1:0] lit,
    input  logic [USER_WIDTH-1:0] user_data_in,
    input  logic                  mem_ready,
    output logic                  result_valid,
    output logic                  branch_valid,
    output logic                  flush_pipeline,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  next_pc_valid,
    output logic [USER_WIDTH-1:0] user_data_out,
    output logic                  ras_overflow
);

    localparam int c_PW = $clog2(RAS_DEPTH);
    localparam int c_CW = c_PW + 1;
    // Payload layout: {taken, next_pc_valid, next_pc, user}
    localparam int c_RW = DATA_WIDTH + USER_WIDTH + 2;
    localparam logic [c_CW-1:0]       c_RAS_FULL    = c_CW'(RAS_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_INSTR_BYTES = DATA_WIDTH'(INSTR_BYTES);

    // ---------------- Return-address stack state ----------------
    logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [c_PW-1:0]       r_ptr;       // next free slot; top is r_ptr-1
    logic [c_CW-1:0]       r_cnt;
    logic                  r_ovf;

    // ---------------- Resolution (combinational) ----------------
    logic                  w_cond;
    logic                  w_taken;
    logic                  w_ras_nonempty;
    logic [DATA_WIDTH-1:0] w_ras_top;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic [c_RW-1:0]       w_payload;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [c_PW-1:0]       w_push_idx;

    always_comb begin
        w_cond = 1'b0;
        case (cond_branch_code)
            4'h0: w_cond = alu_flag_zero;
            4'h1: w_cond = ~alu_flag_zero;
            4'h2: w_cond = alu_flag_carry;
            4'h3: w_cond = ~alu_flag_carry;
            4'h4: w_cond = alu_flag_negative;
            4'h5: w_cond = ~alu_flag_negative;
            4'h6: w_cond = alu_flag_overflow;
            4'h7: w_cond = ~alu_flag_overflow;
            4'h8: w_cond = alu_flag_carry & ~alu_flag_zero;
            4'h9: w_cond = ~alu_flag_carry | alu_flag_zero;
            4'hA: w_cond = ~(alu_flag_negative ^ alu_flag_overflow);
            4'hB: w_cond = alu_flag_negative ^ alu_flag_overflow;
            4'hC: w_cond = ~alu_flag_zero & ~(alu_flag_negative ^ alu_flag_overflow);
            4'hD: w_cond = alu_flag_zero | (alu_flag_negative ^ alu_flag_overflow);
            4'hE: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken        = is_branch & (~is_cond_branch | w_cond);
    assign w_fall         = branch_base_addr + c_INSTR_BYTES;
    assign w_ras_nonempty = (r_cnt != '0);
    assign w_ras_top      = r_ras[r_ptr - c_PW'(1)];
    assign w_target       = (is_return & w_ras_nonempty) ? w_ras_top :
                            branch_rel_abs ? (branch_base_addr + lit) : rn;
    assign w_next_pc      = !is_branch ? '0 : (w_taken ? w_target : w_fall);
    assign w_payload      = {w_taken, is_branch, w_next_pc, user_data_in};

    assign w_accept   = data_valid & branch_ready;
    assign w_pop      = w_accept & w_taken & is_return & w_ras_nonempty;
    assign w_push     = w_accept & w_taken & is_call;
    // A combined call+return replaces the top entry instead of growing the stack.
    assign w_push_idx = w_pop ? (r_ptr - c_PW'(1)) : r_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_push_idx] <= w_fall;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_push && !w_pop) begin
            // When full, the pointer wraps onto the oldest entry.
            r_ptr <= r_ptr + c_PW'(1);
            if (r_cnt == c_RAS_FULL) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end else if (w_pop && !w_push) begin
            r_ptr <= r_ptr - c_PW'(1);
            r_cnt <= r_cnt - c_CW'(1);
        end
    end

    // ---------------- Result pipeline ----------------
    logic            r_s0_v;
    logic [c_RW-1:0] r_s0_d;
    logic            w_s0_adv;
    logic            w_last_v;
    logic [c_RW-1:0] w_last_d;

    assign branch_ready = ~r_s0_v | w_s0_adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0_v <= 1'b0;
            r_s0_d <= '0;
        end else if (branch_ready) begin
            r_s0_v <= data_valid;
            if (data_valid) begin
                r_s0_d <= w_payload;
            end
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic            r_s1_v;
            logic [c_RW-1:0] r_s1_d;

            assign w_s0_adv = ~r_s1_v | mem_ready;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1_v <= 1'b0;
                    r_s1_d <= '0;
                end else if (w_s0_adv) begin
                    r_s1_v <= r_s0_v;
                    if (r_s0_v) begin
                        r_s1_d <= r_s0_d;
                    end
                end
            end

            assign w_last_v = r_s1_v;
            assign w_last_d = r_s1_d;
        end else begin : g_one_stage
            assign w_s0_adv = mem_ready;
            assign w_last_v = r_s0_v;
            assign w_last_d = r_s0_d;
        end
    endgenerate

    assign result_valid   = w_last_v;
    assign {branch_valid, next_pc_valid, next_pc, user_data_out} = w_last_d;
    assign flush_pipeline = branch_valid;
    assign ras_overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_w0rm_core_branch_ras.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_w0rm_core_branch_ras
// Description : Scoreboard bench for w0rm_core_branch_ras. Expected results
//               come from a behavioural model (condition table + queue RAS)
//               and are compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w0rm_core_branch_ras;

    localparam int DW = 32;
    localparam int UW = 1;
    localparam int PS = 2;
    localparam int RD = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          data_valid, branch_ready;
    logic          is_branch, is_cond_branch, is_call, is_return;
    logic [3:0]    cond_branch_code;
    logic          alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow;
    logic [DW-1:0] branch_base_addr, rn, lit;
    logic          branch_rel_abs;
    logic [UW-1:0] user_data_in, user_data_out;
    logic          mem_ready, result_valid, branch_valid, flush_pipeline;
    logic [DW-1:0] next_pc;
    logic          next_pc_valid, ras_overflow;

    w0rm_core_branch_ras #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .PIPE_STAGES(PS),
        .RAS_DEPTH  (RD),
        .INSTR_BYTES(4)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_valid       (data_valid),
        .branch_ready     (branch_ready),
        .is_branch        (is_branch),
        .is_cond_branch   (is_cond_branch),
        .cond_branch_code (cond_branch_code),
        .is_call          (is_call),
        .is_return        (is_return),
        .alu_flag_zero    (alu_flag_zero),
        .alu_flag_negative(alu_flag_negative),
        .alu_flag_carry   (alu_flag_carry),
        .alu_flag_overflow(alu_flag_overflow),
        .branch_base_addr (branch_base_addr),
        .branch_rel_abs   (branch_rel_abs),
        .rn               (rn),
        .lit              (lit),
        .user_data_in     (user_data_in),
        .mem_ready        (mem_ready),
        .result_valid     (result_valid),
        .branch_valid     (branch_valid),
        .flush_pipeline   (flush_pipeline),
        .next_pc          (next_pc),
        .next_pc_valid    (next_pc_valid),
        .user_data_out    (user_data_out),
        .ras_overflow     (ras_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          bv;
        logic          npv;
        logic [DW-1:0] npc;
        logic [UW-1:0] user;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_ras[$];
    bit            m_ovf;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    bit            seen     = 0;
    bit            tgl      = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Condition table written from the flag-letter definitions.
    function automatic bit exp_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic br, input logic cnd, input logic [3:0] code,
                         input logic call, input logic ret, input logic [3:0] f,
                         input logic [DW-1:0] base, input logic rel,
                         input logic [DW-1:0] rnv, input logic [DW-1:0] litv,
                         input bit lat);
        exp_t          e;
        bit            taken, rdy;
        int            n;
        logic [DW-1:0] tgt;
        is_branch         = br;
        is_cond_branch    = cnd;
        cond_branch_code  = code;
        is_call           = call;
        is_return         = ret;
        alu_flag_negative = f[3];
        alu_flag_zero     = f[2];
        alu_flag_carry    = f[1];
        alu_flag_overflow = f[0];
        branch_base_addr  = base;
        branch_rel_abs    = rel;
        rn                = rnv;
        lit               = litv;
        user_data_in      = UW'($urandom_range(0, 1));
        data_valid        = 1'b1;

        taken = br && (!cnd || exp_cond(code, f));
        if (ret && m_ras.size() > 0) tgt = m_ras[$];
        else if (rel)                tgt = base + litv;
        else                         tgt = rnv;
        e.bv   = taken;
        e.npv  = br;
        e.npc  = !br ? '0 : (taken ? tgt : base + 32'd4);
        e.user = user_data_in;
        e.lat  = lat;

        n = 0;
        do begin
            @(negedge clk);
            rdy = branch_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            check_value("accept_timeout", rdy, 1);
        end else begin
            e.acc = cyc;
            sb.push_back(e);
            if (taken) begin
                if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
                if (call) begin
                    m_ras.push_back(base + 32'd4);
                    if (m_ras.size() > RD) begin
                        m_ras.delete(0);
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        data_valid = 1'b0;
        is_branch  = 1'b0;
        is_call    = 1'b0;
        is_return  = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check_value("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the head every cycle it is presented (stall cycles
    // included, so held outputs must keep matching), pop it when consumed.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_n && result_valid) begin
            if (sb.size() == 0) begin
                check_value("spurious_result", result_valid, 0);
            end else begin
                if (!seen) begin
                    seen = 1;
                    if (sb[0].lat) check_value("latency", cyc - sb[0].acc, PS);
                end
                check_value("next_pc", next_pc, sb[0].npc);
                check_value("branch_valid", branch_valid, sb[0].bv);
                check_value("flush", flush_pipeline, sb[0].bv);
                check_value("next_pc_valid", next_pc_valid, sb[0].npv);
                check_value("user_data", user_data_out, sb[0].user);
                if (mem_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tgl) mem_ready = ~mem_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        m_ovf   = 1'b0;
        reset_n = 1'b0;
        mem_ready = 1'b1;
        data_valid = 1'b1;
        is_branch = 1'b1; is_cond_branch = 1'b0; cond_branch_code = 4'h0;
        is_call = 1'b0; is_return = 1'b0;
        {alu_flag_negative, alu_flag_zero, alu_flag_carry, alu_flag_overflow} = 4'h0;
        branch_base_addr = 32'h40; branch_rel_abs = 1'b1; rn = '0; lit = 32'h8;
        user_data_in = 1'b1;

        // 1. Reset held 3 cycles with data_valid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_result_valid", result_valid, 0);
        check_value("rst_branch_valid", branch_valid, 0);
        check_value("rst_flush", flush_pipeline, 0);
        check_value("rst_next_pc", next_pc, 0);
        check_value("rst_next_pc_valid", next_pc_valid, 0);
        check_value("rst_user", user_data_out, 0);
        check_value("rst_ras_overflow", ras_overflow, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        @(negedge clk);
        check_value("rst_branch_ready", branch_ready, 1);
        repeat (3) @(posedge clk);
        #1;

        // 2. Conditional BEQ relative, taken then not taken (latency checked)
        issue(1, 1, 4'h0, 0, 0, 4'b0100, 32'h100, 1, 32'h0, 32'h20, 1);
        drain();
        issue(1, 1, 4'h0, 0, 0, 4'b0000, 32'h100, 1, 32'h0, 32'h20, 1);
        drain();

        // 3. Condition sweep at full throughput
        for (int code = 0; code < 16; code++) begin
            for (int f = 0; f < 16; f++) begin
                issue(1, 1, 4'(code), 0, 0, 4'(f), 32'h1000 + 32'(code * 256 + f * 16), 1, 32'h0, 32'h40, 0);
            end
        end
        // non-branch instruction: zero result, sideband passes
        issue(0, 0, 4'h0, 1, 0, 4'h0, 32'h700, 1, 32'h0, 32'h40, 0);
        drain();

        // 4. Call / return / return on empty RAS
        issue(1, 0, 4'h0, 1, 0, 4'h0, 32'h200, 0, 32'h800, 32'h0, 0);
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h8FC, 0, 32'h0, 32'h0, 0);
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h10, 1, 32'h0, 32'hFFFF_FFFC, 0);
        // not-taken call leaves the stack alone
        issue(1, 1, 4'hF, 1, 0, 4'h0, 32'h300, 0, 32'h900, 32'h0, 0);
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h20, 0, 32'h55, 32'h0, 0);
        // combined call+return: pop supplies target, push replaces top
        issue(1, 0, 4'h0, 1, 0, 4'h0, 32'h500, 0, 32'hA00, 32'h0, 0);
        issue(1, 0, 4'h0, 1, 1, 4'h0, 32'h600, 0, 32'hB00, 32'h0, 0);
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h700, 0, 32'h0, 32'h0, 0);
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h740, 0, 32'h66, 32'h0, 0);
        drain();
        check_value("ras_overflow_clear", ras_overflow, m_ovf);

        // 5. Overflow: RD+1 calls, then RD returns newest-first, then empty pop
        for (int i = 0; i <= RD; i++) begin
            issue(1, 0, 4'h0, 1, 0, 4'h0, 32'(i * 16), 0, 32'h3000, 32'h0, 0);
        end
        for (int i = 0; i < RD; i++) begin
            issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h4000 + 32'(i * 4), 0, 32'h0, 32'h0, 0);
        end
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h5000, 0, 32'h77, 32'h0, 0);
        drain();
        check_value("ras_overflow_set", ras_overflow, m_ovf);

        // 6. Backpressure stream with mem_ready toggling each cycle
        tgl = 1;
        for (int i = 0; i < 9; i++) begin
            issue(1, 1, 4'(i), 0, 0, 4'($urandom_range(0, 15)), 32'h6000 + 32'(i * 8), 1, 32'h0, 32'h100, 0);
        end
        issue(1, 0, 4'h0, 0, 0, 4'h0, 32'hFFFF_FFFC, 1, 32'h0, 32'h8, 0);
        drain();
        tgl = 0;
        mem_ready = 1'b1;

        // Async reset while a result is stalled
        mem_ready = 1'b0;
        issue(1, 0, 4'h0, 0, 0, 4'h0, 32'h900, 1, 32'h0, 32'h10, 0);
        idle();
        repeat (PS + 1) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("async_rst_result_valid", result_valid, 0);
        check_value("async_rst_ras_overflow", ras_overflow, 0);
        sb.delete();
        m_ras.delete();
        m_ovf = 1'b0;
        seen = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_ready = 1'b1;
        issue(1, 0, 4'h0, 0, 1, 4'h0, 32'h80, 0, 32'h1234, 32'h0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
